// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative 32x32 multiply / 32/32 divide unit with HI/LO registers.
// MULTU/MULT use radix-2 shift-add, DIVU/DIV use restoring shift-subtract;
// each takes 32 iterations on one shared add/sub datapath, then a sign-fix cycle.
// Optional feature: define MDU_DIV0_TRAP_EN to make divide-by-zero finish at once
// with err_out set and HI/LO untouched; without it err_out is tied low and a zero
// divisor runs the normal path.
module mul_div_unit (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        start_in,
  input  logic [1:0]  op_in,
  input  logic [31:0] A_in,
  input  logic [31:0] B_in,
  input  logic        hi_we_in,
  input  logic        lo_we_in,
  output logic        busy_out,
  output logic        done_out,
  output logic [31:0] HI_out,
  output logic [31:0] LO_out,
  output logic        err_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_r;
  logic [1:0]  op_r;
  logic [31:0] a_r;        // multiplier (low product half) or dividend/quotient
  logic [31:0] b_r;        // multiplicand or divisor magnitude
  logic [31:0] acc_r;      // high product half or partial remainder
  logic [4:0]  cnt_r;
  logic        sign_a_r;
  logic        sign_b_r;
  logic [31:0] hi_r;
  logic [31:0] lo_r;
  logic        done_r;

  logic [32:0] add_x_s;
  logic [32:0] add_y_s;
  logic [32:0] sum_s;
  logic [63:0] prod_fix_s;
  logic [31:0] quo_fix_s;
  logic [31:0] rem_fix_s;
  logic [31:0] fix_hi_s;
  logic [31:0] fix_lo_s;
  logic        trap_s;

  // Magnitude of a value when the operation is signed, raw value otherwise.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    if (is_signed && v[31]) begin
      return 32'd0 - v;
    end else begin
      return v;
    end
  endfunction

  assign busy_out = (state_r != IDLE);
  assign done_out = done_r;
  assign HI_out   = hi_r;
  assign LO_out   = lo_r;

`ifdef MDU_DIV0_TRAP_EN
  logic err_r;
  assign err_out = err_r;
`else
  assign err_out = 1'b0;
`endif

  // Detect a divide-by-zero request that should short-circuit to DONE.
  always_comb begin
    trap_s = 1'b0;
`ifdef MDU_DIV0_TRAP_EN
    if (op_in[1] && (B_in == 32'd0)) begin
      trap_s = 1'b1;
    end else begin
      trap_s = 1'b0;
    end
`endif
  end

  // Shared add/sub: add multiplicand for multiply, trial-subtract divisor for divide.
  always_comb begin
    add_y_s = {1'b0, b_r};
    if (op_r[1]) begin
      add_x_s = {acc_r, a_r[31]};
      sum_s   = add_x_s - add_y_s;
    end else begin
      add_x_s = {1'b0, acc_r};
      sum_s   = add_x_s + add_y_s;
    end
  end

  // Sign correction of the raw unsigned result and HI/LO selection.
  always_comb begin
    prod_fix_s = {acc_r, a_r};
    quo_fix_s  = a_r;
    rem_fix_s  = acc_r;
    if (sign_a_r ^ sign_b_r) begin
      prod_fix_s = 64'd0 - {acc_r, a_r};
      quo_fix_s  = 32'd0 - a_r;
    end else begin
      prod_fix_s = {acc_r, a_r};
      quo_fix_s  = a_r;
    end
    if (sign_a_r) begin
      rem_fix_s = 32'd0 - acc_r;
    end else begin
      rem_fix_s = acc_r;
    end
    if (op_r[1]) begin
      fix_hi_s = rem_fix_s;
      fix_lo_s = quo_fix_s;
    end else begin
      fix_hi_s = prod_fix_s[63:32];
      fix_lo_s = prod_fix_s[31:0];
    end
  end

  // Control FSM, iteration datapath and HI/LO registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_r  <= IDLE;
      op_r     <= 2'd0;
      a_r      <= 32'd0;
      b_r      <= 32'd0;
      acc_r    <= 32'd0;
      cnt_r    <= 5'd0;
      sign_a_r <= 1'b0;
      sign_b_r <= 1'b0;
      hi_r     <= 32'd0;
      lo_r     <= 32'd0;
      done_r   <= 1'b0;
`ifdef MDU_DIV0_TRAP_EN
      err_r    <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (hi_we_in) begin
            hi_r <= A_in;
          end
          if (lo_we_in) begin
            lo_r <= A_in;
          end
          if (start_in) begin
            op_r     <= op_in;
            a_r      <= mag32(A_in, op_in[0]);
            b_r      <= mag32(B_in, op_in[0]);
            sign_a_r <= op_in[0] & A_in[31];
            sign_b_r <= op_in[0] & B_in[31];
            acc_r    <= 32'd0;
            cnt_r    <= 5'd0;
            if (trap_s) begin
              state_r <= DONE;
              done_r  <= 1'b1;
`ifdef MDU_DIV0_TRAP_EN
              err_r   <= 1'b1;
`endif
            end else begin
              state_r <= CALC;
            end
          end
        end
        CALC: begin
          if (op_r[1]) begin
            // Restoring divide: keep the difference only when no borrow.
            if (sum_s[32]) begin
              acc_r <= add_x_s[31:0];
              a_r   <= {a_r[30:0], 1'b0};
            end else begin
              acc_r <= sum_s[31:0];
              a_r   <= {a_r[30:0], 1'b1};
            end
          end else begin
            // Shift-add multiply: the 65-bit {carry, acc, a} shifts right once.
            if (a_r[0]) begin
              acc_r <= sum_s[32:1];
              a_r   <= {sum_s[0], a_r[31:1]};
            end else begin
              acc_r <= {1'b0, acc_r[31:1]};
              a_r   <= {acc_r[0], a_r[31:1]};
            end
          end
          if (cnt_r == 5'd31) begin
            state_r <= FIX;
          end else begin
            cnt_r <= cnt_r + 5'd1;
          end
        end
        FIX: begin
          hi_r    <= fix_hi_s;
          lo_r    <= fix_lo_s;
          done_r  <= 1'b1;
          state_r <= DONE;
        end
        DONE: begin
          done_r  <= 1'b0;
`ifdef MDU_DIV0_TRAP_EN
          err_r   <= 1'b0;
`endif
          state_r <= IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: a reference model pushes expected
// HI/LO/err and completion cycle into a queue at start; a monitor pops and
// compares on every done_out pulse. Honours MDU_DIV0_TRAP_EN if defined.
module tb_mul_div_unit;

  logic        clk_in;
  logic        rst_n_in;
  logic        start_in;
  logic [1:0]  op_in;
  logic [31:0] A_in;
  logic [31:0] B_in;
  logic        hi_we_in;
  logic        lo_we_in;
  logic        busy_out;
  logic        done_out;
  logic [31:0] HI_out;
  logic [31:0] LO_out;
  logic        err_out;

  typedef struct packed {
    logic [31:0] due;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        err;
  } exp_t;

`ifdef MDU_DIV0_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [31:0] cycle_cnt;
  logic [31:0] model_hi;
  logic [31:0] model_lo;
  int          vectors;
  int          miscompares;

  mul_div_unit dut (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .start_in (start_in),
    .op_in    (op_in),
    .A_in     (A_in),
    .B_in     (B_in),
    .hi_we_in (hi_we_in),
    .lo_we_in (lo_we_in),
    .busy_out (busy_out),
    .done_out (done_out),
    .HI_out   (HI_out),
    .LO_out   (LO_out),
    .err_out  (err_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  initial cycle_cnt = 32'd0;
  always @(posedge clk_in) cycle_cnt = cycle_cnt + 32'd1;

  // Reference model; the due field carries the latency relative to the start edge.
  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
    exp_t r;
    logic [63:0] p;
    logic signed [63:0] sp;
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    r.due = 32'd33;
    r.err = 1'b0;
    r.hi  = 32'd0;
    r.lo  = 32'd0;
    case (op)
      2'b00: begin
        p = {32'd0, a} * {32'd0, b};
        r.hi = p[63:32];
        r.lo = p[31:0];
      end
      2'b01: begin
        sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        r.hi = sp[63:32];
        r.lo = sp[31:0];
      end
      2'b10: begin
        if (b == 32'd0 && TRAP_EN) begin
          r.due = 32'd0; r.err = 1'b1; r.hi = model_hi; r.lo = model_lo;
        end else if (b == 32'd0) begin
          r.hi = a; r.lo = 32'hFFFF_FFFF;
        end else begin
          r.hi = a % b; r.lo = a / b;
        end
      end
      default: begin
        if (b == 32'd0 && TRAP_EN) begin
          r.due = 32'd0; r.err = 1'b1; r.hi = model_hi; r.lo = model_lo;
        end else if (b == 32'd0) begin
          r.hi = a; r.lo = a[31] ? 32'd1 : 32'hFFFF_FFFF;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          r.hi = 32'd0; r.lo = 32'h8000_0000;
        end else begin
          r.hi = sa % sb; r.lo = sa / sb;
        end
      end
    endcase
    return r;
  endfunction

  // Scoreboard monitor: pop and compare on each done pulse, flag late/missing ones.
  always @(negedge clk_in) begin
    if (rst_n_in) begin
      if (done_out) begin
        if (sb_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_done at cycle %0d: done_out=1 required 0", cycle_cnt);
        end else begin
          mon_e = sb_q.pop_front();
          vectors++;
          if (cycle_cnt !== mon_e.due) begin
            miscompares++;
            $display("FAIL latency: done at cycle %0d required %0d", cycle_cnt, mon_e.due);
          end
          vectors++;
          if (HI_out !== mon_e.hi) begin
            miscompares++;
            $display("FAIL sb_hi: HI_out=%h required %h", HI_out, mon_e.hi);
          end
          vectors++;
          if (LO_out !== mon_e.lo) begin
            miscompares++;
            $display("FAIL sb_lo: LO_out=%h required %h", LO_out, mon_e.lo);
          end
          vectors++;
          if (err_out !== mon_e.err) begin
            miscompares++;
            $display("FAIL sb_err: err_out=%b required %b", err_out, mon_e.err);
          end
        end
      end else if (sb_q.size() != 0 && cycle_cnt > sb_q[0].due) begin
        mon_e = sb_q.pop_front();
        vectors++; miscompares++;
        $display("FAIL missing_done: none by cycle %0d required at %0d", cycle_cnt, mon_e.due);
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic wr_hi, input logic wr_lo);
    exp_t e;
    @(negedge clk_in);
    start_in = 1'b1; op_in = op; A_in = a; B_in = b;
    hi_we_in = wr_hi; lo_we_in = wr_lo;
    if (wr_hi) model_hi = a;
    if (wr_lo) model_lo = a;
    e = model(op, a, b);
    @(posedge clk_in); #1;
    e.due = cycle_cnt + e.due;
    sb_q.push_back(e);
    model_hi = e.hi; model_lo = e.lo;
    start_in = 1'b0; hi_we_in = 1'b0; lo_we_in = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || busy_out || done_out) && n < 80) begin
      @(negedge clk_in);
      n++;
    end
    vectors++;
    if (n >= 80) begin
      miscompares++;
      $display("FAIL idle_timeout: busy_out=%b after %0d cycles required 0", busy_out, n);
      sb_q.delete();
    end
  endtask

  task automatic write_hl(input logic wr_hi, input logic wr_lo, input logic [31:0] v);
    @(negedge clk_in);
    hi_we_in = wr_hi; lo_we_in = wr_lo; A_in = v;
    @(posedge clk_in); #1;
    hi_we_in = 1'b0; lo_we_in = 1'b0;
    if (wr_hi) model_hi = v;
    if (wr_lo) model_lo = v;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk_in);
    vectors++;
    if ({busy_out, done_out, err_out, HI_out, LO_out} !== 67'd0) begin
      miscompares++;
      $display("FAIL reset_state: busy=%b done=%b err=%b HI=%h LO=%h required all 0",
               busy_out, done_out, err_out, HI_out, LO_out);
    end
    rst_n_in = 1'b1;
  endtask

  task automatic test_multiply();
    issue(2'b00, 32'd4095, 32'd13121, 1'b0, 1'b0);
    @(negedge clk_in);
    vectors++;
    if (busy_out !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_during_calc: busy_out=%b required 1", busy_out);
    end
    wait_idle();
    vectors++;
    if ({HI_out, LO_out} !== {32'h0000_0000, 32'h0333_DCBF}) begin
      miscompares++;
      $display("FAIL multu_const: HI=%h LO=%h required 00000000 0333dcbf", HI_out, LO_out);
    end
    issue(2'b01, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
    wait_idle();
    vectors++;
    if ({HI_out, LO_out} !== {32'hFFFF_FFFF, 32'hFFFF_FFFA}) begin
      miscompares++;
      $display("FAIL mult_const: HI=%h LO=%h required ffffffff fffffffa", HI_out, LO_out);
    end
    issue(2'b01, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
    wait_idle();
    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    wait_idle();
  endtask

  task automatic test_divide();
    issue(2'b10, 32'd13121, 32'd4095, 1'b0, 1'b0);
    wait_idle();
    vectors++;
    if ({HI_out, LO_out} !== {32'h0000_0344, 32'h0000_0003}) begin
      miscompares++;
      $display("FAIL divu_const: HI=%h LO=%h required 00000344 00000003", HI_out, LO_out);
    end
    issue(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    wait_idle();
    vectors++;
    if ({HI_out, LO_out} !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin
      miscompares++;
      $display("FAIL div_const: HI=%h LO=%h required ffffffff fffffffd", HI_out, LO_out);
    end
    issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    wait_idle();
    vectors++;
    if ({HI_out, LO_out} !== {32'h0000_0000, 32'h8000_0000}) begin
      miscompares++;
      $display("FAIL div_overflow: HI=%h LO=%h required 00000000 80000000", HI_out, LO_out);
    end
    issue(2'b11, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0);
    wait_idle();
    issue(2'b10, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
    wait_idle();
  endtask

  task automatic test_mthi_mtlo();
    write_hl(1'b1, 1'b0, 32'hA5A5_0001);
    write_hl(1'b0, 1'b1, 32'h5A5A_0002);
    vectors++;
    if ({HI_out, LO_out} !== {32'hA5A5_0001, 32'h5A5A_0002}) begin
      miscompares++;
      $display("FAIL mthi_mtlo: HI=%h LO=%h required a5a50001 5a5a0002", HI_out, LO_out);
    end
    issue(2'b00, 32'h0000_0010, 32'd3, 1'b0, 1'b1);
    vectors++;
    if (LO_out !== 32'h0000_0010) begin
      miscompares++;
      $display("FAIL mtlo_with_start: LO=%h required 00000010", LO_out);
    end
    wait_idle();
  endtask

  task automatic test_div_zero();
    write_hl(1'b1, 1'b1, 32'h1234_5678);
    issue(2'b10, 32'd5, 32'd0, 1'b0, 1'b0);
    wait_idle();
    vectors++;
    if (LO_out !== (TRAP_EN ? 32'h1234_5678 : 32'hFFFF_FFFF)) begin
      miscompares++;
      $display("FAIL divu_zero_lo: LO=%h required %h", LO_out,
               TRAP_EN ? 32'h1234_5678 : 32'hFFFF_FFFF);
    end
    issue(2'b11, 32'hFFFF_FFF9, 32'd0, 1'b0, 1'b0);
    wait_idle();
  endtask

  task automatic test_busy_ignore();
    issue(2'b10, 32'd13121, 32'd4095, 1'b0, 1'b0);
    repeat (5) @(negedge clk_in);
    start_in = 1'b1; op_in = 2'b00; A_in = 32'hDEAD_BEEF; B_in = 32'd2;
    hi_we_in = 1'b1; lo_we_in = 1'b1;
    @(posedge clk_in); #1;
    start_in = 1'b0; hi_we_in = 1'b0; lo_we_in = 1'b0;
    vectors++;
    if (HI_out === 32'hDEAD_BEEF || LO_out === 32'hDEAD_BEEF || busy_out !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_write: HI=%h LO=%h busy=%b required no write, busy 1",
               HI_out, LO_out, busy_out);
    end
    wait_idle();
    repeat (40) @(negedge clk_in);
    vectors++;
    if ({HI_out, LO_out} !== {32'h0000_0344, 32'h0000_0003}) begin
      miscompares++;
      $display("FAIL busy_ignore: HI=%h LO=%h required 00000344 00000003", HI_out, LO_out);
    end
  endtask

  task automatic test_reset_abort();
    exp_t e;
    issue(2'b00, 32'd4095, 32'd13121, 1'b0, 1'b0);
    repeat (10) @(negedge clk_in);
    rst_n_in = 1'b0;
    sb_q.delete();
    model_hi = 32'd0; model_lo = 32'd0;
    #1;
    vectors++;
    if ({busy_out, done_out, HI_out, LO_out} !== 66'd0) begin
      miscompares++;
      $display("FAIL reset_abort: busy=%b done=%b HI=%h LO=%h required all 0",
               busy_out, done_out, HI_out, LO_out);
    end
    repeat (3) @(negedge clk_in);
    rst_n_in = 1'b1;
    start_in = 1'b1; op_in = 2'b00; A_in = 32'd3; B_in = 32'd5;
    e = model(2'b00, 32'd3, 32'd5);
    @(posedge clk_in); #1;
    e.due = cycle_cnt + e.due;
    sb_q.push_back(e);
    model_hi = e.hi; model_lo = e.lo;
    start_in = 1'b0;
    wait_idle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 12; i++) begin
      a = $urandom();
      b = (i % 5 == 4) ? 32'd0 : $urandom();
      if (i % 3 == 2) b = b >> $urandom_range(31, 16);
      issue(i[1:0], a, b, 1'b0, 1'b0);
      wait_idle();
      vectors++;
      if ({HI_out, LO_out} !== {model_hi, model_lo}) begin
        miscompares++;
        $display("FAIL b2b_%0d: HI=%h LO=%h required %h %h", i, HI_out, LO_out,
                 model_hi, model_lo);
      end
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst_n_in = 1'b0; start_in = 1'b0; op_in = 2'b00;
    A_in = 32'd0; B_in = 32'd0; hi_we_in = 1'b0; lo_we_in = 1'b0;
    model_hi = 32'd0; model_lo = 32'd0;
    test_reset();
    test_multiply();
    test_divide();
    test_mthi_mtlo();
    test_div_zero();
    test_busy_ignore();
    test_reset_abort();
    test_back_to_back();
    repeat (3) @(negedge clk_in);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset; ports `clk_in` and `rst_n_in`.
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- `clk_in`, in, 1: clock, rising edge.
- `rst_n_in`, in, 1: asynchronous reset, active low.
- `start_in`, in, 1: request an operation.
- `op_in`, in, 2: operation select; 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- `A_in`, in, 32: multiplicand or dividend.
- `B_in`, in, 32: multiplier or divisor.
- `hi_we_in`, in, 1: MTHI write strobe.
- `lo_we_in`, in, 1: MTLO write strobe.
- `busy_out`, out, 1: operation in progress.
- `done_out`, out, 1: one-cycle completion pulse.
- `HI_out`, out, 32: HI register.
- `LO_out`, out, 32: LO register.
- `err_out`, out, 1: divide-by-zero flag.

Function
REQ-003 The FSM SHALL have states IDLE, CALC, FIX and DONE; `busy_out` = (state != IDLE).
REQ-004 IDLE with `start_in`=1 at edge E0 SHALL latch `op_in`, |`A_in`|, |`B_in`| and the operand signs, clear the iteration counter and go to CALC; magnitudes are taken only for MULT/DIV.
REQ-005 In IDLE with `start_in`=0, the FSM SHALL stay in IDLE.
REQ-006 `start_in` SHALL be ignored while `busy_out`=1; no queuing.
REQ-007 CALC SHALL perform exactly 32 iterations, one per clock, using a single internal 32-bit add/sub datapath:
- multiply: radix-2 shift-add;
- divide: restoring shift-subtract.
REQ-008 After the 32nd iteration the FSM SHALL go to FIX.
REQ-009 FIX SHALL apply sign correction, write HI/LO, and go to DONE:
- MULT: 64-bit product negated when signs differ.
- DIV quotient: negated when signs differ (truncation toward zero).
- DIV remainder: takes the dividend's sign.
REQ-010 DONE SHALL assert `done_out`=1 for exactly one cycle, then return to IDLE unconditionally.
REQ-011 Normal latency SHALL be: `done_out` high in the cycle following edge E0+33.
REQ-012 Multiply results SHALL be HI = product[63:32], LO = product[31:0].
REQ-013 Divide results SHALL be LO = quotient, HI = remainder.
REQ-014 DIV 0x80000000 / 0xFFFFFFFF SHALL yield LO=0x80000000, HI=0x00000000, `err_out`=0.
REQ-015 `HI_out`/`LO_out` SHALL change only in FIX, or on MTHI/MTLO writes in IDLE; they hold their value at all other times.
REQ-016 In IDLE, `hi_we_in`/`lo_we_in` SHALL load `A_in` into HI/LO at the clock edge.
REQ-017 MTHI/MTLO writes SHALL be ignored while `busy_out`=1.
REQ-018 If a write and `start_in` occur in the same IDLE cycle, both SHALL take effect; the later FIX overwrites HI/LO.

Reset
REQ-019 While `rst_n_in`=0 the block SHALL asynchronously force:
- state = IDLE;
- `HI_out` = `LO_out` = 0;
- `busy_out` = `done_out` = `err_out` = 0;
- counter and operand registers = 0.
REQ-020 Reset asserted mid-operation SHALL abort it with no `done_out`.
REQ-021 After reset release, the first rising edge SHALL be able to accept `start_in`.

Configuration
REQ-022 With macro `MDU_DIV0_TRAP_EN` defined, DIV/DIVU with `B_in`=0 SHALL behave as follows:
- the FSM goes IDLE→DONE at E0 (skipping CALC/FIX);
- `done_out` and `err_out` are both 1 in the next cycle;
- HI/LO are unchanged.
REQ-023 Without `MDU_DIV0_TRAP_EN`, `err_out` SHALL be tied 0 and divide-by-zero SHALL run the full 33-cycle path:
- unsigned result: LO=0xFFFFFFFF, HI=|dividend|;
- FIX sign rules (REQ-009) are then applied.

Verification
REQ-024 MULTU A=4095, B=13121 → after 33 cycles, `done_out` pulse with HI=0x00000000, LO=0x0333DCBF.
REQ-025 MULT A=0xFFFFFFFE, B=3 → HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-026 DIVU A=13121, B=4095 → LO=0x00000003, HI=0x00000344; DIV A=0xFFFFFFF9, B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-027 Divide by zero: DIVU A=5, B=0 with MTLO 0x12345678 loaded beforehand:
- macro on → `done_out`=`err_out`=1 one cycle after start, LO still 0x12345678;
- macro off → LO=0xFFFFFFFF, HI=5.
REQ-028 Start MULTU 4095×13121, pulse `rst_n_in` low at CALC iteration 10 → immediately `busy_out`=0, HI=LO=0, no `done_out`; a second `start_in` during a busy DIVU is ignored.
